// File: rtl/p2s_8_1_if.sv
// Byte-stream to serial-lane bundle for the PCIe TX byte-to-serial stage.
// master = byte source / lane observer, slave = the serializer.
interface p2s_8_1_if;
  logic [7:0] data_32_8;
  logic       valid_32_8;
  logic       data_out;
  logic       sym_start;
  logic       active;
  logic       synced;

  modport master (
    output data_32_8, valid_32_8,
    input  data_out, sym_start, active, synced
  );

  modport slave (
    input  data_32_8, valid_32_8,
    output data_out, sym_start, active, synced
  );
endinterface

// File: rtl/p2s_8_1.sv
// Byte-to-serial stage: shifts one symbol MSB-first every 8 clk_32f cycles,
// sending IDLE_SYM during post-reset link sync and whenever no valid byte is offered.
//
// state | meaning
// SYNC  | forcing IDLE_SYM; counting idle loads up to COM_MIN
// READY | link synced; valid bytes sent as data, otherwise IDLE_SYM
module p2s_8_1 #(
  parameter logic [7:0] IDLE_SYM = 8'hBC,
  parameter int         COM_MIN  = 4
) (
  input  logic        clk_32f,
  input  logic        reset,
  p2s_8_1_if.slave    bus
);

  localparam int CW = $clog2(COM_MIN + 1);

  typedef enum logic {SYNC, READY} state_t;

  state_t          state, state_nxt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic [CW-1:0]   com_cnt, com_cnt_nxt;
  logic            sym_start_q, active_q, synced_q;
  logic            load;
  logic [7:0]      sym_nxt;
  logic            active_nxt, synced_nxt;

  // bit_cnt resets to 7 so the very first edge after reset is a load edge
  assign load = (bit_cnt == 3'd7);

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state       <= SYNC;
      bit_cnt     <= 3'd7;
      shreg       <= 8'h00;
      com_cnt     <= '0;
      sym_start_q <= 1'b0;
      active_q    <= 1'b0;
      synced_q    <= 1'b0;
    end else begin
      state       <= state_nxt;
      bit_cnt     <= bit_cnt + 3'd1;
      shreg       <= load ? sym_nxt : {shreg[6:0], 1'b0};
      com_cnt     <= com_cnt_nxt;
      sym_start_q <= load;
      active_q    <= active_nxt;
      synced_q    <= synced_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    com_cnt_nxt = com_cnt;
    sym_nxt     = IDLE_SYM;
    active_nxt  = active_q;
    synced_nxt  = synced_q;
    if (load) begin
      case (state)
        SYNC: begin
          active_nxt = 1'b0;
          if (com_cnt != CW'(COM_MIN))
            com_cnt_nxt = com_cnt + CW'(1);
          // the COM_MIN-th idle load itself raises synced
          if (com_cnt == CW'(COM_MIN - 1)) begin
            state_nxt  = READY;
            synced_nxt = 1'b1;
          end
        end
        READY: begin
          if (bus.valid_32_8) begin
            sym_nxt    = bus.data_32_8;
            active_nxt = 1'b1;
          end else begin
            active_nxt = 1'b0;
          end
        end
        default: state_nxt = SYNC;
      endcase
    end
  end

  assign bus.data_out  = shreg[7];
  assign bus.sym_start = sym_start_q;
  assign bus.active    = active_q;
  assign bus.synced    = synced_q;

endmodule

// File: tb/tb_p2s_8_1.sv
// Directed bench for p2s_8_1: per-slot vector table plus hand-written
// reset and mid-symbol reset sequences.
module tb_p2s_8_1;

  logic clk_32f = 1'b0;
  logic reset   = 1'b0;
  int   total   = 0;
  int   bad     = 0;

  p2s_8_1_if bus ();

  p2s_8_1 dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .bus     (bus.slave)
  );

  always #5 clk_32f = ~clk_32f;

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic [7:0] exp_sym;
    logic       exp_act;
    logic       exp_sync;
    logic       mid_change;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Call while the next rising edge is a load edge; checks n_bits cycles of the slot.
  task automatic run_slot(input vec_t v, input int n_bits);
    bus.data_32_8  = v.data;
    bus.valid_32_8 = v.valid;
    for (int i = 0; i < n_bits; i++) begin
      @(posedge clk_32f);
      #1;
      chk("data_out",  bus.data_out,  v.exp_sym[7-i]);
      chk("sym_start", bus.sym_start, (i == 0));
      chk("active",    bus.active,    v.exp_act);
      chk("synced",    bus.synced,    v.exp_sync);
      if (v.mid_change && i == 3) begin
        bus.data_32_8  = ~v.data;
        bus.valid_32_8 = ~v.valid;
      end
    end
  endtask

  initial begin
    // sync after reset with valid data offered (dropped), then 0x3C
    vecs[0]  = '{8'h3C, 1'b1, 8'hBC, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'h3C, 1'b1, 8'hBC, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{8'h3C, 1'b1, 8'hBC, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{8'h3C, 1'b1, 8'hBC, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{8'h3C, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0};
    // data / idle mix
    vecs[5]  = '{8'hA5, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{8'h77, 1'b0, 8'hBC, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
    // mid-slot input changes must not disturb the symbol in flight
    vecs[9]  = '{8'h96, 1'b1, 8'h96, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{8'h11, 1'b0, 8'hBC, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{8'hC3, 1'b1, 8'hC3, 1'b1, 1'b1, 1'b1};
    // data byte equal to the idle symbol is still data
    vecs[12] = '{8'hBC, 1'b1, 8'hBC, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{8'h5A, 1'b0, 8'hBC, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{8'h81, 1'b1, 8'h81, 1'b1, 1'b1, 1'b0};
    vecs[15] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0};

    // T1: held in reset with random inputs
    bus.data_32_8  = 8'h00;
    bus.valid_32_8 = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.data_32_8  = 8'($urandom);
      bus.valid_32_8 = 1'($urandom);
      @(posedge clk_32f);
      #1;
      chk("rst_data_out",  bus.data_out,  1'b0);
      chk("rst_sym_start", bus.sym_start, 1'b0);
      chk("rst_active",    bus.active,    1'b0);
      chk("rst_synced",    bus.synced,    1'b0);
    end
    reset = 1'b1;

    // T2..T4, T6: vector table
    for (int s = 0; s < 16; s++)
      run_slot(vecs[s], 8);

    // T5: reset while bit 3 of 0xA5 is on the lane
    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0};
    run_slot(vecs[0], 5);
    reset = 1'b0;
    #1;
    chk("midrst_data_out",  bus.data_out,  1'b0);
    chk("midrst_sym_start", bus.sym_start, 1'b0);
    chk("midrst_active",    bus.active,    1'b0);
    chk("midrst_synced",    bus.synced,    1'b0);
    repeat (3) @(posedge clk_32f);
    #1;
    reset = 1'b1;
    for (int s = 0; s < 4; s++) begin
      vecs[0] = '{8'hA5, 1'b1, 8'hBC, 1'b0, (s == 3), 1'b0};
      run_slot(vecs[0], 8);
    end
    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0};
    run_slot(vecs[0], 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
